// File: rtl/lut_ram_wr_arb.sv
// lut_ram_wr_arb
//   Arbitrates two write requesters onto the single write port of a shared
//   lut_ram. With LUT_RAM_WR_ARB_INIT_EN defined, a clear sweep writes zero
//   to every address after reset before any requester is served.
//
//   Optional feature macro: LUT_RAM_WR_ARB_INIT_EN (INIT sweep present).
//
//   Ports
//     clk, reset            block clock; asynchronous active-high reset
//     req0_valid/addr/data  requester 0 write request
//     req0_ready            requester 0 write accepted this cycle
//     req1_*                same as req0_* for requester 1
//     init_busy             clear sweep in progress
//     ram_wr_en/addr/data   lut_ram write port
module lut_ram_wr_arb #(
    parameter int LUT_WIDTH = 32,
    parameter int LUT_DEPTH = 256,
    localparam int AW = $clog2(LUT_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [AW-1:0]        req0_addr,
    input  logic [LUT_WIDTH-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [AW-1:0]        req1_addr,
    input  logic [LUT_WIDTH-1:0] req1_data,
    output logic                 req1_ready,
    output logic                 init_busy,
    output logic                 ram_wr_en,
    output logic [AW-1:0]        ram_wr_addr,
    output logic [LUT_WIDTH-1:0] ram_wr_data
);

    logic          run;        // arbitration enabled this cycle
    logic          sweep_en;   // clear sweep writes this cycle
    logic [AW-1:0] sweep_addr;
    logic          grant0;
    logic          grant1;
    logic          prio_q;     // requester favoured on contention
    logic          prio_d;

`ifdef LUT_RAM_WR_ARB_INIT_EN
    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic          state_q;
    logic          state_d;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            // Leave INIT on the edge that writes the last address.
            if (cnt_q == AW'(LUT_DEPTH - 1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset gates the outputs combinationally so nothing is written or
    // accepted while reset is held, even between clock edges.
    assign init_busy  = (state_q == ST_INIT);
    assign sweep_en   = (state_q == ST_INIT) && !reset;
    assign sweep_addr = cnt_q;
    assign run        = (state_q == ST_RUN) && !reset;
`else
    assign init_busy  = 1'b0;
    assign sweep_en   = 1'b0;
    assign sweep_addr = '0;
    assign run        = !reset;
`endif

    // A lone requester wins immediately; on contention prio_q decides.
    assign grant0 = run && req0_valid && (!req1_valid || !prio_q);
    assign grant1 = run && req1_valid && (!req0_valid ||  prio_q);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Favour the other requester after every transfer; hold otherwise.
    always_comb begin
        prio_d = prio_q;
        if (grant0) begin
            prio_d = 1'b1;
        end else if (grant1) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        ram_wr_en   = 1'b0;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        if (sweep_en) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = sweep_addr;
        end else if (grant0) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = req0_addr;
            ram_wr_data = req0_data;
        end else if (grant1) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = req1_addr;
            ram_wr_data = req1_data;
        end
    end

endmodule

// File: tb/tb_lut_ram_wr_arb.sv
module tb_lut_ram_wr_arb;

    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic [7:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        init_busy;
    logic        ram_wr_en;
    logic [7:0]  ram_wr_addr;
    logic [31:0] ram_wr_data;

    int total;
    int bad;

`ifdef LUT_RAM_WR_ARB_INIT_EN
    logic init_en_exp = 1'b1;
`else
    logic init_en_exp = 1'b0;
`endif

    // Behavioural lut_ram driven by the DUT write port (write latency 1).
    logic [31:0] mem [256];

    lut_ram_wr_arb #(.LUT_WIDTH(32), .LUT_DEPTH(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .init_busy  (init_busy),
        .ram_wr_en  (ram_wr_en),
        .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    endtask

    // Reset, release, and wait (bounded) until requesters can be served.
    task automatic do_reset();
        int n;
        idle_inputs();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        n = 0;
        while (init_busy && n < 600) begin
            next_cycle();
            n++;
        end
        if (init_busy) begin
            total++; bad++;
            $display("FAIL reset_wait: init_busy still %0b after %0d cycles, want 0", init_busy, n);
        end
    endtask

    task automatic test_reset();
        // Requests pending while reset asserts must not be accepted.
        next_cycle();
        req0_valid = 1'b1; req0_addr = 8'h05; req0_data = 32'h5;
        req1_valid = 1'b1; req1_addr = 8'h06; req1_data = 32'h6;
        reset = 1'b1;
        #1;
        total++;
        if (init_busy !== init_en_exp) begin
            bad++; $display("FAIL reset_busy_async: init_busy=%0b want %0b", init_busy, init_en_exp);
        end
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready, ram_wr_en} !== 3'b000) begin
            bad++; $display("FAIL reset_outputs: r0=%0b r1=%0b wr_en=%0b want 0 0 0", req0_ready, req1_ready, ram_wr_en);
        end
        total++;
        if (init_busy !== init_en_exp) begin
            bad++; $display("FAIL reset_busy_held: init_busy=%0b want %0b", init_busy, init_en_exp);
        end
        idle_inputs();
    endtask

`ifdef LUT_RAM_WR_ARB_INIT_EN
    // Counts sweep cycles after release; checks address, zero data, readys.
    task automatic check_sweep(input string name);
        int n;
        logic ok;
        n = 0; ok = 1'b1;
        req0_valid = 1'b1; req0_addr = 8'hAA; req0_data = 32'hAAAA_AAAA;
        req1_valid = 1'b1; req1_addr = 8'hBB; req1_data = 32'hBBBB_BBBB;
        @(negedge clk);
        while (init_busy && n < 600) begin
            if (ram_wr_en !== 1'b1 || ram_wr_addr !== n[7:0] || ram_wr_data !== 32'h0 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                if (ok) $display("FAIL %s_write: cycle %0d en=%0b addr=%0d data=%h r0=%0b r1=%0b want 1 %0d 0 0 0",
                                 name, n, ram_wr_en, ram_wr_addr, ram_wr_data, req0_ready, req1_ready, n);
                ok = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        total++;
        if (!ok) bad++;
        total++;
        if (n !== 256) begin
            bad++; $display("FAIL %s_len: init_busy cycles=%0d want 256", name, n);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_init_sweep();
        int nz;
        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'hFFFF_FFFF;
        next_cycle();
        reset = 1'b0;
        check_sweep("sweep");
        nz = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 32'h0) nz++;
        total++;
        if (nz !== 0) begin
            bad++; $display("FAIL sweep_cleared: nonzero words=%0d want 0", nz);
        end
    endtask

    task automatic test_reset_mid_sweep();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        repeat (100) next_cycle();
        @(negedge clk);
        total++;
        if (ram_wr_addr !== 8'd100 || init_busy !== 1'b1) begin
            bad++; $display("FAIL midsweep_pos: addr=%0d busy=%0b want 100 1", ram_wr_addr, init_busy);
        end
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        check_sweep("resweep");
    endtask
`endif

    task automatic test_no_req();
        idle_inputs();
        req0_addr = 8'h33; req0_data = 32'h3333_3333;
        @(negedge clk);
        total++;
        if ({ram_wr_en, req0_ready, req1_ready} !== 3'b000 || ram_wr_addr !== 8'h0 || ram_wr_data !== 32'h0) begin
            bad++; $display("FAIL no_req: en=%0b r0=%0b r1=%0b addr=%h data=%h want 0 0 0 00 0",
                            ram_wr_en, req0_ready, req1_ready, ram_wr_addr, ram_wr_data);
        end
        next_cycle();
    endtask

    task automatic test_single();
        idle_inputs();
        req0_valid = 1'b1; req0_addr = 8'h10; req0_data = 32'hDEAD_BEEF;
        @(negedge clk);
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || ram_wr_en !== 1'b1 ||
            ram_wr_addr !== 8'h10 || ram_wr_data !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL single0: r0=%0b r1=%0b en=%0b addr=%h data=%h want 1 0 1 10 deadbeef",
                            req0_ready, req1_ready, ram_wr_en, ram_wr_addr, ram_wr_data);
        end
        next_cycle();
        idle_inputs();
        total++;
        if (mem[8'h10] !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL single0_read: mem[10]=%h want deadbeef", mem[8'h10]);
        end
        req1_valid = 1'b1; req1_addr = 8'h11; req1_data = 32'hCAFE_F00D;
        @(negedge clk);
        total++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || ram_wr_addr !== 8'h11 || ram_wr_data !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL single1: r1=%0b r0=%0b addr=%h data=%h want 1 0 11 cafef00d",
                            req1_ready, req0_ready, ram_wr_addr, ram_wr_data);
        end
        next_cycle();
        idle_inputs();
        total++;
        if (mem[8'h11] !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL single1_read: mem[11]=%h want cafef00d", mem[8'h11]);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g [4];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        do_reset();
        req0_valid = 1'b1; req0_addr = 8'h01; req0_data = 32'hA0A0_0001;
        req1_valid = 1'b1; req1_addr = 8'h02; req1_data = 32'hB0B0_0002;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({req1_ready, req0_ready} !== exp_g[i] ||
                ram_wr_addr !== (exp_g[i][0] ? 8'h01 : 8'h02)) begin
                bad++; $display("FAIL alternate[%0d]: ready{1,0}=%b addr=%h want %b %h", i,
                                {req1_ready, req0_ready}, ram_wr_addr, exp_g[i], exp_g[i][0] ? 8'h01 : 8'h02);
            end
            next_cycle();
        end
        idle_inputs();
        total++;
        if (mem[8'h01] !== 32'hA0A0_0001 || mem[8'h02] !== 32'hB0B0_0002) begin
            bad++; $display("FAIL alternate_mem: mem[1]=%h mem[2]=%h want a0a00001 b0b00002", mem[8'h01], mem[8'h02]);
        end
    endtask

    task automatic test_prio_hold();
        do_reset();
        req0_valid = 1'b1; req0_addr = 8'h40; req0_data = 32'h40;
        req1_valid = 1'b1; req1_addr = 8'h41; req1_data = 32'h41;
        next_cycle();          // requester 0 wins, prio moves to 1
        req0_valid = 1'b0; req1_valid = 1'b0;
        next_cycle();          // no transfer: prio must hold at 1
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        total++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            bad++; $display("FAIL prio_hold: ready{1,0}=%b want 10", {req1_ready, req0_ready});
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_same_addr();
        do_reset();
        req0_valid = 1'b1; req0_addr = 8'h20; req0_data = 32'h1111_1111;
        req1_valid = 1'b1; req1_addr = 8'h20; req1_data = 32'h2222_2222;
        @(negedge clk);
        total++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            bad++; $display("FAIL same_addr_first: ready{1,0}=%b want 01", {req1_ready, req0_ready});
        end
        next_cycle();
        req0_valid = 1'b0;
        total++;
        if (mem[8'h20] !== 32'h1111_1111) begin
            bad++; $display("FAIL same_addr_mid: mem[20]=%h want 11111111", mem[8'h20]);
        end
        @(negedge clk);
        total++;
        if (req1_ready !== 1'b1) begin
            bad++; $display("FAIL same_addr_second: r1=%0b want 1", req1_ready);
        end
        next_cycle();
        idle_inputs();
        total++;
        if (mem[8'h20] !== 32'h2222_2222) begin
            bad++; $display("FAIL same_addr_final: mem[20]=%h want 22222222", mem[8'h20]);
        end
    endtask

    // Random valids; each requester holds its request until accepted.
    task automatic test_random();
        logic        pend [2];
        logic [7:0]  a    [2];
        logic [31:0] d    [2];
        int          wt   [2];
        logic        mprio, e0, e1, en_exp;
        logic [7:0]  ea;
        logic [31:0] ed;
        int          errs, starve;
        do_reset();
        pend[0] = 1'b0; pend[1] = 1'b0; wt[0] = 0; wt[1] = 0;
        mprio = 1'b0; errs = 0; starve = 0;
        for (int c = 0; c < 1000; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1'b1;
                    a[r] = 8'($urandom_range(0, 255));
                    d[r] = $urandom;
                end
            end
            req0_valid = pend[0]; req0_addr = a[0]; req0_data = d[0];
            req1_valid = pend[1]; req1_addr = a[1]; req1_data = d[1];
            e0 = pend[0] && (!pend[1] || !mprio);
            e1 = pend[1] && (!pend[0] ||  mprio);
            en_exp = e0 || e1;
            ea = e0 ? a[0] : (e1 ? a[1] : 8'h0);
            ed = e0 ? d[0] : (e1 ? d[1] : 32'h0);
            @(negedge clk);
            if (req0_ready !== e0 || req1_ready !== e1 || ram_wr_en !== en_exp ||
                ram_wr_addr !== ea || ram_wr_data !== ed) begin
                if (errs < 5) $display("FAIL random[%0d]: r0=%0b r1=%0b en=%0b addr=%h data=%h want %0b %0b %0b %h %h",
                                       c, req0_ready, req1_ready, ram_wr_en, ram_wr_addr, ram_wr_data,
                                       e0, e1, en_exp, ea, ed);
                errs++;
            end
            if (e0) begin pend[0] = 1'b0; wt[0] = 0; mprio = 1'b1; end
            else if (pend[0]) wt[0]++;
            if (e1) begin pend[1] = 1'b0; wt[1] = 0; mprio = 1'b0; end
            else if (pend[1]) wt[1]++;
            if (wt[0] > 1 || wt[1] > 1) starve++;
            next_cycle();
        end
        idle_inputs();
        total++;
        if (errs !== 0) begin
            bad++; $display("FAIL random_log: mismatched cycles=%0d want 0", errs);
        end
        total++;
        if (starve !== 0) begin
            bad++; $display("FAIL random_starve: cycles waiting >1=%0d want 0", starve);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
`ifdef LUT_RAM_WR_ARB_INIT_EN
        test_init_sweep();
        test_reset_mid_sweep();
`endif
        do_reset();
        test_no_req();
        test_single();
        test_alternate();
        test_prio_hold();
        test_same_addr();
        test_random();
        next_cycle();
        test_reset();
        reset = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
